// File: rtl/ucdp_latch_regf.sv
// Latch-array register file: writes are staged in flops and land in the latches during the low
// clock phase of the following cycle; reads are registered; a sequential clear engine resets all
// entries one per cycle.
module ucdp_latch_regf #(
  parameter int unsigned        width_p  = 8,
  parameter int unsigned        depth_p  = 8,
  parameter logic [width_p-1:0] rstval_p = '0,
  localparam int unsigned       addrw_p  = (depth_p > 2) ? $clog2(depth_p) : 1
) (
  input  logic               main_clk_i,
  input  logic               main_rst_an_i,
  input  logic               dft_mode_test_mode_i,
  input  logic               dft_mode_scan_mode_i,
  input  logic               dft_mode_scan_shift_i,
  input  logic               dft_mode_mbist_mode_i,
  input  logic               wr_en_i,
  input  logic [addrw_p-1:0] wr_addr_i,
  input  logic [width_p-1:0] wr_data_i,
  input  logic [width_p-1:0] wr_mask_i,
  input  logic               rd_en_i,
  input  logic [addrw_p-1:0] rd_addr_i,
  output logic [width_p-1:0] rd_data_o,
  input  logic               clr_i,
  output logic               clr_busy_o,
  output logic               wr_drop_o
);

  localparam logic [addrw_p-1:0] last_idx_p = addrw_p'(depth_p - 1);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e             state_q, state_d;
  logic [addrw_p-1:0] clr_cnt_q, clr_cnt_d;
  logic               busy;
  logic               wr_in_range;

  logic               stg_en_d, stg_en_q;
  logic [addrw_p-1:0] stg_addr_d, stg_addr_q;
  logic [width_p-1:0] stg_data_d, stg_data_q;
  logic [width_p-1:0] stg_mask_d, stg_mask_q;

  logic               wr_drop_d, wr_drop_q;
  logic [width_p-1:0] rd_mux, rd_data_q;

  logic [depth_p-1:0][width_p-1:0] mem;

  assign busy        = (state_q == StClear);
  assign wr_in_range = 32'(wr_addr_i) < depth_p;

  // Clear engine: clr_i while clearing restarts the sweep from entry 0.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (clr_i) begin
          state_d   = StClear;
          clr_cnt_d = '0;
        end
      end
      StClear: begin
        if (clr_i) begin
          clr_cnt_d = '0;
        end else if (clr_cnt_q == last_idx_p) begin
          state_d   = StIdle;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = StIdle;
        clr_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
    if (!main_rst_an_i) begin
      state_q   <= StIdle;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // While clearing, the staging slot belongs to the clear engine and user writes are dropped.
  always_comb begin
    stg_en_d   = wr_en_i & wr_in_range;
    stg_addr_d = wr_addr_i;
    stg_data_d = wr_data_i;
    stg_mask_d = wr_mask_i;
    wr_drop_d  = wr_en_i & ~wr_in_range;
    if (busy) begin
      stg_en_d   = 1'b1;
      stg_addr_d = clr_cnt_q;
      stg_data_d = rstval_p;
      stg_mask_d = '1;
      wr_drop_d  = wr_en_i;
    end
  end

  always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
    if (!main_rst_an_i) begin
      stg_en_q   <= 1'b0;
      stg_addr_q <= '0;
      stg_data_q <= '0;
      stg_mask_q <= '0;
      wr_drop_q  <= 1'b0;
    end else begin
      stg_en_q   <= stg_en_d;
      stg_addr_q <= stg_addr_d;
      stg_data_q <= stg_data_d;
      stg_mask_q <= stg_mask_d;
      wr_drop_q  <= wr_drop_d;
    end
  end

  // Storage
  for (genvar e = 0; e < depth_p; e++) begin : g_entry
    logic [width_p-1:0] entry_q;
`ifdef FPGA
    // Flops take the write one stage early so port timing matches the latch variant.
    logic sel_d;
    assign sel_d = stg_en_d && (stg_addr_d == addrw_p'(e));

    always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
      if (!main_rst_an_i) begin
        entry_q <= rstval_p;
      end else if (sel_d) begin
        entry_q <= (entry_q & ~stg_mask_d) | (stg_data_d & stg_mask_d);
      end
    end
`else
    logic               sel;
    logic [width_p-1:0] lat_en;
    assign sel    = stg_en_q && (stg_addr_q == addrw_p'(e)) && !main_clk_i;
    assign lat_en = dft_mode_scan_mode_i ? '1 : (stg_mask_q & {width_p{sel}});

    always_latch begin
      if (!main_rst_an_i) begin
        entry_q = rstval_p;
      end else begin
        for (int unsigned b = 0; b < width_p; b++) begin
          if (lat_en[b]) begin
            entry_q[b] = stg_data_q[b];
          end
        end
      end
    end
`endif
    assign mem[e] = entry_q;
  end

  // Out-of-range read addresses fall through to the reset value.
  always_comb begin
    rd_mux = rstval_p;
    for (int unsigned i = 0; i < depth_p; i++) begin
      if (rd_addr_i == addrw_p'(i)) begin
        rd_mux = mem[i];
      end
    end
  end

  always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
    if (!main_rst_an_i) begin
      rd_data_q <= rstval_p;
    end else if (rd_en_i) begin
      rd_data_q <= rd_mux;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign clr_busy_o = busy;
  assign wr_drop_o  = wr_drop_q;

  logic unused_dft;
  assign unused_dft = ^{dft_mode_test_mode_i, dft_mode_scan_shift_i, dft_mode_mbist_mode_i};
`ifdef FPGA
  logic unused_fpga;
  assign unused_fpga = ^{dft_mode_scan_mode_i, stg_en_q, stg_addr_q, stg_data_q, stg_mask_q};
`endif

endmodule
